// File: rtl/dvfs_opp_sequencer.sv
// DVFS operating-point sequencer: orders VR and PLL handshakes so voltage is
// always high enough for the frequency being applied, and reports the live OPP.
module dvfs_opp_sequencer #(
  parameter int unsigned SETTLE_CYCLES  = 64,
  parameter int unsigned TIMEOUT_CYCLES = 4096,
  parameter logic [15:0] BOOT_MV        = 16'd750,
  parameter logic [31:0] BOOT_FREQ      = 32'd400_000_000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic [2:0]  opp_req_index,
  input  logic [31:0] freq_req,
  input  logic [15:0] volt_req,
  output logic        vr_req,
  output logic [15:0] vr_set_mv,
  input  logic        vr_ack,
  output logic        pll_req,
  output logic [31:0] pll_freq,
  input  logic        pll_lock,
  output logic [2:0]  cur_opp,
  output logic        busy,
  output logic        done,
  output logic        fault,
  input  logic        fault_clear
);

  localparam int unsigned MAX_CNT = (SETTLE_CYCLES > TIMEOUT_CYCLES) ? SETTLE_CYCLES : TIMEOUT_CYCLES;
  localparam int unsigned CNT_W   = ($clog2(MAX_CNT + 1) > 16) ? $clog2(MAX_CNT + 1) : 16;
  localparam logic [CNT_W-1:0] SETTLE_LAST  = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE, V_UP, V_SETTLE, F_CHG, V_DOWN, V_SETTLE_DN
  } state_t;

  state_t           state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [2:0]       tgt_idx, tgt_idx_n;
  logic [31:0]      tgt_f, tgt_f_n;
  logic [15:0]      tgt_v, tgt_v_n;
  logic             down, down_n;
  logic             vr_req_n, pll_req_n, busy_n, done_n, fault_n;
  logic [15:0]      vr_set_mv_n;
  logic [31:0]      pll_freq_n;
  logic [2:0]       cur_opp_n;
  logic             timeout_c;

  assign timeout_c = (cnt == TIMEOUT_LAST);

  // State and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      tgt_idx   <= '0;
      tgt_f     <= '0;
      tgt_v     <= '0;
      down      <= 1'b0;
      vr_req    <= 1'b0;
      vr_set_mv <= BOOT_MV;
      pll_req   <= 1'b0;
      pll_freq  <= BOOT_FREQ;
      cur_opp   <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      fault     <= 1'b0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      tgt_idx   <= tgt_idx_n;
      tgt_f     <= tgt_f_n;
      tgt_v     <= tgt_v_n;
      down      <= down_n;
      vr_req    <= vr_req_n;
      vr_set_mv <= vr_set_mv_n;
      pll_req   <= pll_req_n;
      pll_freq  <= pll_freq_n;
      cur_opp   <= cur_opp_n;
      busy      <= busy_n;
      done      <= done_n;
      fault     <= fault_n;
    end
  end

  // Next-state and next-output logic
  always_comb begin
    state_n     = state;
    cnt_n       = cnt;
    tgt_idx_n   = tgt_idx;
    tgt_f_n     = tgt_f;
    tgt_v_n     = tgt_v;
    down_n      = down;
    vr_req_n    = vr_req;
    vr_set_mv_n = vr_set_mv;
    pll_req_n   = pll_req;
    pll_freq_n  = pll_freq;
    cur_opp_n   = cur_opp;
    busy_n      = busy;
    done_n      = 1'b0;
    fault_n     = fault;

    case (state)
      IDLE: begin
        if (fault_clear) fault_n = 1'b0;
        if (enable && !fault && (opp_req_index != cur_opp)) begin
          tgt_idx_n = opp_req_index;
          tgt_f_n   = freq_req;
          tgt_v_n   = volt_req;
          busy_n    = 1'b1;
          cnt_n     = '0;
          // Equal voltage still goes through the VR handshake first
          if (volt_req >= vr_set_mv) begin
            down_n      = 1'b0;
            state_n     = V_UP;
            vr_req_n    = 1'b1;
            vr_set_mv_n = volt_req;
          end else begin
            down_n     = 1'b1;
            state_n    = F_CHG;
            pll_req_n  = 1'b1;
            pll_freq_n = freq_req;
          end
        end
      end

      V_UP, V_DOWN: begin
        if (vr_ack) begin
          vr_req_n = 1'b0;
          cnt_n    = '0;
          state_n  = (state == V_UP) ? V_SETTLE : V_SETTLE_DN;
        end else if (timeout_c) begin
          vr_req_n = 1'b0;
          fault_n  = 1'b1;
          busy_n   = 1'b0;
          state_n  = IDLE;
        end else begin
          cnt_n = cnt + CNT_W'(1);
        end
      end

      V_SETTLE: begin
        if (cnt == SETTLE_LAST) begin
          cnt_n      = '0;
          state_n    = F_CHG;
          pll_req_n  = 1'b1;
          pll_freq_n = tgt_f;
        end else begin
          cnt_n = cnt + CNT_W'(1);
        end
      end

      F_CHG: begin
        if (pll_lock) begin
          pll_req_n = 1'b0;
          cnt_n     = '0;
          if (down) begin
            state_n     = V_DOWN;
            vr_req_n    = 1'b1;
            vr_set_mv_n = tgt_v;
          end else begin
            state_n   = IDLE;
            cur_opp_n = tgt_idx;
            done_n    = 1'b1;
            busy_n    = 1'b0;
          end
        end else if (timeout_c) begin
          pll_req_n = 1'b0;
          fault_n   = 1'b1;
          busy_n    = 1'b0;
          state_n   = IDLE;
        end else begin
          cnt_n = cnt + CNT_W'(1);
        end
      end

      V_SETTLE_DN: begin
        if (cnt == SETTLE_LAST) begin
          state_n   = IDLE;
          cur_opp_n = tgt_idx;
          done_n    = 1'b1;
          busy_n    = 1'b0;
        end else begin
          cnt_n = cnt + CNT_W'(1);
        end
      end

      default: state_n = IDLE;
    endcase
  end

endmodule
